// File: rtl/wb_spi_pkg.sv
// wb_spi_pkg: register map, status/control bit positions and SPI FSM encoding
package wb_spi_pkg;
  localparam int REG_DATA = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_CTRL = 2;
  localparam int REG_CLKDIV = 3;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_OVR = 2;
  localparam int CTRL_CS_EN = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LEAD = 2'd1;
  localparam logic [1:0] S_TRAIL = 2'd2;
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 SPI byte shifter with programmable half-period divider
module spi_shift_engine
  import wb_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic [7:0] clkdiv,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx
);
  logic [1:0] state;
  logic [7:0] div;
  logic [7:0] tx;
  logic [2:0] cnt;
  assign busy = state != S_IDLE;
  // done marks the final expiring cycle so the owner can latch rx on the same edge BUSY drops
  assign done = state == S_TRAIL && div == 8'd0 && cnt == 3'd0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      div <= 8'd0;
      tx <= 8'd0;
      cnt <= 3'd0;
      sclk <= 1'b0;
      mosi <= 1'b0;
      rx <= 8'd0;
    end else if (state == S_IDLE) begin
      if (start) begin
        state <= S_LEAD;
        div <= clkdiv;
        tx <= tx_byte;
        cnt <= 3'd7;
        mosi <= tx_byte[7];
        sclk <= 1'b0;
      end
    end else if (div != 8'd0) begin
      div <= div - 8'd1;
    end else begin
      div <= clkdiv;
      if (state == S_LEAD) begin
        state <= S_TRAIL;
        sclk <= 1'b1;
        rx <= {rx[6:0], miso};
      end else if (cnt != 3'd0) begin
        state <= S_LEAD;
        sclk <= 1'b0;
        tx <= {tx[6:0], 1'b0};
        mosi <= tx[6];
        cnt <= cnt - 3'd1;
      end else begin
        state <= S_IDLE;
        sclk <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/wb_spi_master.sv
// wb_spi_master: Wishbone register bank in front of a mode-0 SPI master.
// Define WB_SPI_IRQ_EN to add the registered irq_o output and the CTRL.IRQ_EN bit.
module wb_spi_master
  import wb_spi_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV = 8'd4,
  parameter int ADR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic             wb_sel_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic [7:0]       wb_dat_i,
  output logic [7:0]       wb_dat_o,
  output logic             wb_ack_o,
  output logic             spi_sclk_o,
  output logic             spi_mosi_o,
  input  logic             spi_miso_i,
  output logic             spi_cs_n_o
`ifdef WB_SPI_IRQ_EN
  ,output logic            irq_o
`endif
);
  logic req, wr, rd, hit_data, hit_status, hit_ctrl, hit_div, start;
  logic busy, xfer_done, done_flag, ovr, cs_en, irq_en;
  logic [7:0] rx, rx_reg, clkdiv, status, ctrl, rd_data;
  assign req = wb_cyc_i & wb_stb_i;
  assign wr = req & wb_we_i & wb_sel_i;
  assign rd = req & ~wb_we_i;
  assign hit_data = wb_adr_i == ADR_W'(REG_DATA);
  assign hit_status = wb_adr_i == ADR_W'(REG_STATUS);
  assign hit_ctrl = wb_adr_i == ADR_W'(REG_CTRL);
  assign hit_div = wb_adr_i == ADR_W'(REG_CLKDIV);
  assign start = wr & hit_data & ~busy;
  assign spi_cs_n_o = ~cs_en;
  always_comb begin
    status = 8'd0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_flag;
    status[ST_OVR] = ovr;
    ctrl = 8'd0;
    ctrl[CTRL_CS_EN] = cs_en;
    ctrl[CTRL_IRQ_EN] = irq_en;
    rd_data = hit_data ? rx_reg : hit_status ? status : hit_ctrl ? ctrl : hit_div ? clkdiv : 8'd0;
  end
  spi_shift_engine u_engine (
    .clk(clk),
    .reset(reset),
    .start(start),
    .tx_byte(wb_dat_i),
    .clkdiv(clkdiv),
    .miso(spi_miso_i),
    .sclk(spi_sclk_o),
    .mosi(spi_mosi_o),
    .busy(busy),
    .done(xfer_done),
    .rx(rx)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 8'd0;
      rx_reg <= 8'd0;
      clkdiv <= DEFAULT_DIV;
      done_flag <= 1'b0;
      ovr <= 1'b0;
      cs_en <= 1'b0;
    end else begin
      wb_ack_o <= req;
      if (rd) wb_dat_o <= rd_data;
      if (xfer_done) rx_reg <= rx;
      // sets are ORed in last so they win over a same-cycle clear
      done_flag <= xfer_done | (done_flag & ~(wr & hit_status & wb_dat_i[ST_DONE]) & ~(rd & hit_data));
      ovr <= (wr & hit_data & busy) | (ovr & ~(wr & hit_status & wb_dat_i[ST_OVR]));
      if (wr & hit_ctrl) cs_en <= wb_dat_i[CTRL_CS_EN];
      if (wr & hit_div) clkdiv <= wb_dat_i;
    end
  end
`ifdef WB_SPI_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr & hit_ctrl) irq_en <= wb_dat_i[CTRL_IRQ_EN];
      irq_o <= irq_en & done_flag;
    end
  end
`else
  assign irq_en = 1'b0;
`endif
endmodule

// File: tb/tb_wb_spi_master.sv
// tb_wb_spi_master: randomized bench for wb_spi_master against a cycle-count register model
module tb_wb_spi_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0, wb_sel = 1'b0;
  logic [4:0] wb_adr = 5'd0;
  logic [7:0] wb_dat = 8'd0;
  logic [7:0] wb_dat_o;
  logic wb_ack_o, sclk, mosi, cs_n, miso;
  logic loop_mode = 1'b0;
  logic [7:0] slave = 8'd0, sb = 8'd0;
`ifdef WB_SPI_IRQ_EN
  logic irq;
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  wb_spi_master dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .spi_sclk_o(sclk), .spi_mosi_o(mosi), .spi_miso_i(miso), .spi_cs_n_o(cs_n)
`ifdef WB_SPI_IRQ_EN
    , .irq_o(irq)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  assign miso = loop_mode ? mosi : sb[7];
  logic mq[$];
  time rq[$];
  always @(posedge sclk) begin
    mq.push_back(mosi);
    rq.push_back($time);
  end
  always @(negedge sclk) sb = {sb[6:0], 1'b0};
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // reference model: registers plus the edge at which the running transfer completes
  bit m_busy, m_done, m_ovr, m_cs, m_irqen;
  logic [7:0] m_rx, m_div, m_ptx, m_prx, m_sdiv;
  int m_end;
  task automatic model_reset();
    m_busy = 0; m_done = 0; m_ovr = 0; m_cs = 0; m_irqen = 0;
    m_rx = 8'd0; m_div = 8'd4; m_end = 0;
  endtask
  task automatic complete();
    m_busy = 0; m_done = 1; m_rx = m_prx;
  endtask
  function automatic logic [7:0] model_read(input logic [4:0] adr);
    case (adr)
      5'd0: return m_rx;
      5'd1: return {5'd0, m_ovr, m_done, m_busy};
      5'd2: return {6'd0, m_irqen, m_cs};
      5'd3: return m_div;
      default: return 8'd0;
    endcase
  endfunction
  task automatic wb(input logic we, input logic sel, input logic [4:0] adr, input logic [7:0] d, output logic [7:0] q);
    int e;
    logic [7:0] exp_q;
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat = d;
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 0;
    e = cyc;
    if (m_busy && m_end <= e - 1) complete();
    exp_q = model_read(adr);
    if (we && sel) begin
      case (adr)
        5'd0: if (m_busy) m_ovr = 1;
              else begin
                m_busy = 1; m_end = e + 16 * (int'(m_div) + 1); m_sdiv = m_div;
                m_ptx = d; m_prx = loop_mode ? d : slave; sb = slave;
                mq.delete(); rq.delete();
              end
        5'd1: begin if (d[1]) m_done = 0; if (d[2]) m_ovr = 0; end
        5'd2: begin m_cs = d[0]; m_irqen = IRQ ? d[1] : 1'b0; end
        5'd3: m_div = d;
        default: ;
      endcase
    end
    if (!we && adr == 5'd0) m_done = 0;
    if (m_busy && m_end == e) complete();
    check($sformatf("ack_a%0d", adr), wb_ack_o, 1);
    if (!we) check($sformatf("rd_a%0d", adr), wb_dat_o, exp_q);
    q = wb_dat_o;
  endtask
  task automatic wait_idle();
    logic [7:0] q;
    int n = 0;
    do begin
      wb(0, 1, 5'd1, 8'd0, q);
      n++;
    end while (q[0] && n < 3000);
    check("busy_timeout", q[0], 0);
  endtask
  task automatic check_xfer();
    logic [7:0] b = 8'd0;
    int bad = 0;
    foreach (mq[i]) b = {b[6:0], mq[i]};
    check("mosi_bits", b, m_ptx);
    check("sclk_rises", mq.size(), 8);
    for (int i = 1; i < rq.size(); i++)
      if (rq[i] - rq[i-1] != 64'(20 * (int'(m_sdiv) + 1))) bad++;
    check("sclk_period", bad, 0);
  endtask
  task automatic wait_edge(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] q;
    int e0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    reset = 0;
    for (int a = 0; a < 32; a++) wb(0, 1, 5'(a), 8'd0, q);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_sel = 1; wb_adr = 5'd3;
    @(posedge clk); #1;
    check("b2b_ack0", wb_ack_o, 1);
    check("b2b_dat0", wb_dat_o, m_div);
    wb_adr = 5'd2;
    @(posedge clk); #1;
    wb_cyc = 0; wb_stb = 0;
    check("b2b_ack1", wb_ack_o, 1);
    check("b2b_dat1", wb_dat_o, {6'd0, m_irqen, m_cs});
    @(posedge clk); #1;
    check("ack_drop", wb_ack_o, 0);
    wb(1, 0, 5'd3, 8'h77, q);
    wb(0, 1, 5'd3, 8'd0, q);
    wb(1, 0, 5'd0, 8'h55, q);
    wb(0, 1, 5'd1, 8'd0, q);
    // loopback byte at full speed
    loop_mode = 1;
    wb(1, 1, 5'd3, 8'd0, q);
    wb(1, 1, 5'd2, 8'h01, q);
    wb(1, 1, 5'd0, 8'hA5, q);
    check("cs_active", cs_n, 0);
    wait_idle();
    check_xfer();
    wb(0, 1, 5'd0, 8'd0, q);
    wb(0, 1, 5'd1, 8'd0, q);
    // overrun while busy
    wb(1, 1, 5'd3, 8'd4, q);
    wb(1, 1, 5'd0, 8'h3C, q);
    wb(1, 1, 5'd0, 8'hFF, q);
    wb(0, 1, 5'd1, 8'd0, q);
    wb(1, 1, 5'd1, 8'h04, q);
    wb(0, 1, 5'd1, 8'd0, q);
    wait_idle();
    check_xfer();
    wb(0, 1, 5'd0, 8'd0, q);
    // W1C of DONE and DATA read landing on the completion edge
    wb(1, 1, 5'd3, 8'd0, q);
    wb(1, 1, 5'd0, 8'h96, q);
    wait_edge(m_end - 1);
    wb(1, 1, 5'd1, 8'h02, q);
    wb(0, 1, 5'd1, 8'd0, q);
    wb(1, 1, 5'd0, 8'h69, q);
    wait_edge(m_end - 1);
    wb(0, 1, 5'd0, 8'd0, q);
    wb(0, 1, 5'd1, 8'd0, q);
    wb(0, 1, 5'd0, 8'd0, q);
    // randomized transfers with traffic during BUSY
    for (int it = 0; it < 16; it++) begin
      logic [4:0] a;
      logic we;
      wb(1, 1, 5'd3, 8'($urandom_range(0, 3)), q);
      wb(1, 1, 5'd2, 8'($urandom_range(0, 3)), q);
      loop_mode = 1'($urandom_range(0, 1));
      slave = 8'($urandom);
      wb(1, 1, 5'd0, 8'($urandom), q);
      check("cs_n", cs_n, !m_cs);
      repeat ($urandom_range(0, 3)) begin
        a = 5'($urandom_range(0, 7));
        we = 1'($urandom_range(0, 1));
        if (we && a == 5'd3) a = 5'd5;
        wb(we, 1'($urandom_range(0, 1)), a, 8'($urandom), q);
      end
      wait_idle();
      check_xfer();
      wb(0, 1, 5'd0, 8'd0, q);
    end
`ifdef WB_SPI_IRQ_EN
    loop_mode = 0;
    slave = 8'hC3;
    wb(1, 1, 5'd2, 8'h03, q);
    wb(1, 1, 5'd0, 8'h5A, q);
    wait_edge(m_end);
    check("irq_lag", irq, 0);
    @(posedge clk); #1;
    check("irq_rise", irq, 1);
    wb(0, 1, 5'd0, 8'd0, q);
    check("irq_hold", irq, 1);
    @(posedge clk); #1;
    check("irq_fall", irq, 0);
    check_xfer();
`endif
    // reset in the middle of a CLKDIV=1 transfer
    loop_mode = 0;
    slave = 8'hF0;
    wb(1, 1, 5'd3, 8'd1, q);
    wb(1, 1, 5'd2, 8'h01, q);
    wb(1, 1, 5'd0, 8'hE7, q);
    e0 = m_end - 32;
    wait_edge(e0 + 6);
    check("pre_rst_sclk", sclk, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
    check("abort_sclk", sclk, 0);
    check("abort_cs_n", cs_n, 1);
    check("abort_ack", wb_ack_o, 0);
    wb(0, 1, 5'd1, 8'd0, q);
    wb(0, 1, 5'd3, 8'd0, q);
    wb(0, 1, 5'd2, 8'd0, q);
    repeat (40) @(posedge clk);
    #1;
    wb(0, 1, 5'd1, 8'd0, q);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_spi_master.md
Name: wb_spi_master

Overview:
- Wishbone slave that sits directly downstream of the EPB-to-Wishbone bridge.
- Consumes the bridge's single-cycle cyc/stb requests and exposes a small 8-bit register bank.
- Drives a mode-0 SPI master for configuration flash and peripheral access.
- Every request is acknowledged one cycle after strobe, so the bridge never stalls.

Parameters:
- DEFAULT_DIV, 8'd4, reset value of CLKDIV; SPI half-period = (CLKDIV+1) clk cycles.
- ADR_W, 5, Wishbone address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe; may be high for one cycle only
- wb_we_i  in  1  1 = write
- wb_sel_i  in  1  byte enable; writes with sel=0 are acked but ignored
- wb_adr_i  in  ADR_W  register address
- wb_dat_i  in  8  write data
- wb_dat_o  out  8  read data, registered, valid with ack
- wb_ack_o  out  1  single-cycle acknowledge
- spi_sclk_o  out  1  SPI clock, idles low
- spi_mosi_o  out  1  SPI data out
- spi_miso_i  in  1  SPI data in
- spi_cs_n_o  out  1  chip select, active low
- irq_o  out  1  present only with WB_SPI_IRQ_EN

Behaviour:
- Reset state:
  - wb_ack_o=0, wb_dat_o=0.
  - spi_sclk_o=0, spi_mosi_o=0, spi_cs_n_o=1.
  - CLKDIV=DEFAULT_DIV; all other registers 0; FSM in IDLE.
- Wishbone handshake:
  - A request is accepted in any cycle with wb_cyc_i & wb_stb_i.
  - wb_ack_o pulses high for exactly the next cycle; latency is always 1, including while a transfer is busy.
  - wb_dat_o is loaded on the acking cycle and held until the next read.
  - Back-to-back strobes produce back-to-back acks.
- Register map (8-bit):
  - 0 DATA:
    - Write: loads the TX shift register and starts a transfer if idle.
    - Write while busy: data discarded and STATUS.OVR set.
    - Read: returns the last received byte and clears STATUS.DONE.
  - 1 STATUS:
    - bit0 BUSY (read-only).
    - bit1 DONE (sticky, write-1-clear).
    - bit2 OVR (sticky, write-1-clear).
    - bits7:3 read 0.
  - 2 CTRL:
    - bit0 CS_EN: spi_cs_n_o = !CS_EN, software-controlled.
    - bit1 IRQ_EN.
    - Other bits read 0.
  - 3 CLKDIV: read/write.
  - Addresses 4-31: read 0, writes ignored, still acked.
- SPI FSM states: IDLE, LEAD (sclk low half), TRAIL (sclk high half).
  - IDLE -> LEAD on an accepted DATA write with sel=1. At that point, load the bit counter with 7 and drive MOSI with TX[7].
  - LEAD -> TRAIL when the divider expires. Raise sclk and sample MISO into RX[0] while shifting RX left.
  - TRAIL -> LEAD when the divider expires and bits remain. Lower sclk, shift TX left, drive MOSI with the new bit 7, and decrement the counter.
  - TRAIL -> IDLE when the divider expires and the counter is 0. Lower sclk, copy RX to the DATA read register, set DONE, clear BUSY.
- Timing:
  - Divider reloads with CLKDIV on each state entry.
  - BUSY is high from the cycle after strobe for exactly 16*(CLKDIV+1) cycles.
  - CLKDIV changes during a transfer take effect at the next half-period.
- Simultaneous events:
  - A DONE/OVR set in the same cycle as a write-1-clear: the set wins.
  - A DATA read in the same cycle as transfer completion: returns the old byte, and DONE ends up set.
- Reset mid-transfer: immediate abort to the reset state; no DONE.

Optional Feature:
- WB_SPI_IRQ_EN defined: adds the irq_o port, registered, irq_o = IRQ_EN & DONE. It rises the cycle after DONE sets.
- Macro undefined: no irq_o port; CTRL.IRQ_EN reads 0 and ignores writes.

Decomposition:
- Shared package wb_spi_pkg holds:
  - register address constants (REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_CLKDIV=3);
  - STATUS/CTRL bit-index constants;
  - FSM state encoding.
- One sub-module, spi_shift_engine: the FSM, divider, shift registers and bit counter.
- The top level holds the Wishbone decode and the register bank.

Test Plan:
- Write CLKDIV=0, CTRL=0x01, DATA=0xA5, with MISO looped to MOSI. Required response:
  - spi_cs_n_o=0;
  - 8 sclk rising edges, one every 2 cycles;
  - MOSI sequence 1,0,1,0,0,1,0,1;
  - BUSY for 16 cycles, then DONE=1;
  - DATA reads 0xA5 and DONE clears.
- Single-cycle strobe reads of addresses 0-31 right after reset: each ack arrives exactly one cycle later with data 0 (addr3 returns 0x04); no stall.
- Write DATA=0x3C, then DATA=0xFF while BUSY. Required response: second write acked; STATUS=0x05; shifted byte remains 0x3C; writing STATUS=0x04 clears OVR only.
- Assert reset at cycle 5 of a CLKDIV=1 transfer. Required response: next cycle sclk=0, cs_n=1, STATUS=0x00, CLKDIV=0x04.
- Write STATUS=0x02 in the same cycle the transfer completes. Required response: DONE reads 1.
- With WB_SPI_IRQ_EN, write CTRL=0x02 and complete a transfer. Required response: irq_o rises the cycle after DONE and falls the cycle after a DATA read.
